// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the 4bpp sprite pixel decoders.
//   PIX_PER_WORD    : packed colour indices per 32-bit sprite ROM word
//   IDX_W           : colour index width (4bpp)
//   RGB_W           : colour width delivered by the palette block
//   TRANSPARENT_IDX : colour index that is never drawn
//   pick_idx()      : selects one packed index out of a ROM word
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int IDX_W        = 4;
  localparam int RGB_W        = 24;
  localparam int NIB_W        = $clog2(PIX_PER_WORD);
  localparam int ROM_DW       = PIX_PER_WORD * IDX_W;
  localparam int CMAP_N       = 1 << IDX_W;

  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef rgb_t color_map_t [0:CMAP_N-1];

  // Pixel k of a ROM word lives at bits [IDX_W*k +: IDX_W].
  function automatic logic [IDX_W-1:0] pick_idx(
    input logic [ROM_DW-1:0] word,
    input logic [NIB_W-1:0]  nib
  );
    return word[IDX_W*nib +: IDX_W];
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// sprite_addr_gen
// Combinational sprite-relative address math for one screen pixel request.
// Ports:
//   i_x, i_y          : screen coordinate of the request
//   i_pos_x, i_pos_y  : sprite top-left screen coordinate
//   i_flip            : horizontal mirror
//   o_inb             : request lies inside the sprite rectangle
//   o_rom_addr        : ROM word holding the pixel (meaningful only if o_inb)
//   o_nib             : pixel slot inside that word
// SPRITE_W must be a power of two (multiple of 8) and ROM_AW must equal
// log2(SPRITE_W*SPRITE_H/8).
// -----------------------------------------------------------------------------
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 32,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int ROM_AW   = 8
)(
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  input  logic [X_W-1:0]    i_pos_x,
  input  logic [Y_W-1:0]    i_pos_y,
  input  logic              i_flip,
  output logic              o_inb,
  output logic [ROM_AW-1:0] o_rom_addr,
  output logic [NIB_W-1:0]  o_nib
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int LIN_W = ROM_AW + NIB_W;

  // One extra bit keeps the difference signed, so a request left of / above
  // the sprite is negative instead of wrapping to a large positive value.
  logic signed [X_W:0]  w_rel_x;
  logic signed [Y_W:0]  w_rel_y;
  logic signed [31:0]   w_rel_x_i;
  logic signed [31:0]   w_rel_y_i;
  logic [COL_W-1:0]     w_rel_x_lo;
  logic [COL_W-1:0]     w_col;
  logic [LIN_W-1:0]     w_lin;

  assign w_rel_x = $signed({1'b0, i_x}) - $signed({1'b0, i_pos_x});
  assign w_rel_y = $signed({1'b0, i_y}) - $signed({1'b0, i_pos_y});

  // Sign-extend to 32 bits so the bounds compare against the parameters
  // cannot truncate for any legal sprite size.
  assign w_rel_x_i = 32'(w_rel_x);
  assign w_rel_y_i = 32'(w_rel_y);

  assign o_inb = (w_rel_x_i >= 0) && (w_rel_x_i < SPRITE_W) &&
                 (w_rel_y_i >= 0) && (w_rel_y_i < SPRITE_H);

  // SPRITE_W is a power of two, so SPRITE_W-1-rel_x is the bitwise
  // complement of the in-range column bits.
  assign w_rel_x_lo = w_rel_x[COL_W-1:0];
  assign w_col      = i_flip ? ~w_rel_x_lo : w_rel_x_lo;

  // rel_y*SPRITE_W + col: the multiply is a shift for a power-of-two width.
  assign w_lin = (LIN_W'($unsigned(w_rel_y)) << COL_W) | LIN_W'(w_col);

  assign o_rom_addr = w_lin[LIN_W-1:NIB_W];
  assign o_nib      = w_lin[NIB_W-1:0];

endmodule

// File: rtl/sprite_pixel_decoder.sv
// -----------------------------------------------------------------------------
// sprite_pixel_decoder
// Turns scan-out pixel requests into RGB for one 4bpp sprite. Three-stage
// pipeline with a single global advance:
//   S0 : bounds/flip/address math, issue the synchronous ROM read
//   S1 : ROM word arrives, pick the 4-bit colour index
//   S2 : look the index up in the live palette, drive RGB + opaque
// Ports:
//   i_clk, i_rst                         : clock, synchronous active-high reset
//   i_frame_start, i_sprite_x/_y, i_flip_h : latch sprite placement (bypassed
//                                          to a request in the same cycle)
//   i_valid, o_ready, i_x, i_y           : pixel request handshake
//   i_color_map                          : 16-entry palette, read live at S2
//   o_rom_en, o_rom_addr, i_rom_data     : synchronous sprite ROM port
//   o_valid, i_ready, o_rgb, o_opaque    : pixel output handshake
// -----------------------------------------------------------------------------
module sprite_pixel_decoder
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 32,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int ROM_AW   = 8
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic [X_W-1:0]    i_sprite_x,
  input  logic [Y_W-1:0]    i_sprite_y,
  input  logic              i_flip_h,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  input  logic [RGB_W-1:0]  i_color_map [0:CMAP_N-1],
  output logic              o_rom_en,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [ROM_DW-1:0] i_rom_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [RGB_W-1:0]  o_rgb,
  output logic              o_opaque
);

  // Latched sprite placement
  logic [X_W-1:0]    r_pos_x;
  logic [Y_W-1:0]    r_pos_y;
  logic              r_flip;

  // Last address issued to the ROM, held across stalls and bubbles
  logic [ROM_AW-1:0] r_rom_addr;

  // Stage registers
  logic              r_v1;
  logic              r_inb1;
  logic [NIB_W-1:0]  r_nib1;
  logic              r_v2;
  logic [IDX_W-1:0]  r_idx2;

  // S0 combinational
  logic [X_W-1:0]    w_pos_x;
  logic [Y_W-1:0]    w_pos_y;
  logic              w_flip;
  logic              w_inb;
  logic [ROM_AW-1:0] w_addr;
  logic [NIB_W-1:0]  w_nib;
  logic              w_adv;
  logic              w_accept;

  // S1 combinational
  logic [IDX_W-1:0]  w_idx1;

  // ---------------------------------------------------------------------------
  // S0: placement bypass, address generation, ROM request
  // ---------------------------------------------------------------------------
  // A frame_start in the same cycle as a request applies to that request.
  assign w_pos_x = i_frame_start ? i_sprite_x : r_pos_x;
  assign w_pos_y = i_frame_start ? i_sprite_y : r_pos_y;
  assign w_flip  = i_frame_start ? i_flip_h   : r_flip;

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .ROM_AW   (ROM_AW)
  ) u_addr_gen (
    .i_x        (i_x),
    .i_y        (i_y),
    .i_pos_x    (w_pos_x),
    .i_pos_y    (w_pos_y),
    .i_flip     (w_flip),
    .o_inb      (w_inb),
    .o_rom_addr (w_addr),
    .o_nib      (w_nib)
  );

  // The whole pipeline moves together; it only freezes when a finished pixel
  // is sitting at the output and downstream refuses it.
  assign w_adv    = !(o_valid && !i_ready);
  assign o_ready  = w_adv;
  assign w_accept = w_adv && i_valid && !i_rst;

  // Out-of-bounds requests never touch the ROM. Keeping the enable low while
  // stalled freezes the ROM output register, so S1 sees a stable word.
  assign o_rom_en   = w_accept && w_inb;
  assign o_rom_addr = o_rom_en ? w_addr : r_rom_addr;

  // ---------------------------------------------------------------------------
  // S1: index select; out-of-bounds pixels become transparent
  // ---------------------------------------------------------------------------
  assign w_idx1 = r_inb1 ? pick_idx(i_rom_data, r_nib1) : TRANSPARENT_IDX;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's value from before this edge, regardless of order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_flip     <= 1'b0;
      r_rom_addr <= '0;
      r_v1       <= 1'b0;
      r_inb1     <= 1'b0;
      r_nib1     <= '0;
      r_v2       <= 1'b0;
      r_idx2     <= TRANSPARENT_IDX;
    end else begin
      // Placement is independent of the pipeline; the last pulse wins.
      if (i_frame_start) begin
        r_pos_x <= i_sprite_x;
        r_pos_y <= i_sprite_y;
        r_flip  <= i_flip_h;
      end

      if (o_rom_en) begin
        r_rom_addr <= w_addr;
      end

      if (w_adv) begin
        r_v1   <= i_valid;
        // Bubbles carry inb=0 so they leave S1 as a transparent index.
        r_inb1 <= i_valid && w_inb;
        r_nib1 <= w_nib;
        r_v2   <= r_v1;
        r_idx2 <= w_idx1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: live palette lookup
  // ---------------------------------------------------------------------------
  assign o_valid  = r_v2;
  assign o_opaque = (r_idx2 != TRANSPARENT_IDX);
  assign o_rgb    = o_opaque ? i_color_map[r_idx2] : '0;

endmodule
